// File: rtl/butterfly_pkg.sv
// rtl/butterfly_pkg.sv - shared types and constants for the butterfly operand/result sequencer
package butterfly_pkg;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_FIRE = 3'd1,
    ST_WAIT = 3'd2,
    ST_SHOW = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  typedef logic signed [7:0] data_t;

  localparam int         NUM_OPS  = 4;
  localparam logic [1:0] IDX_LAST = 2'(NUM_OPS - 1);
  localparam data_t      ERR_CODE = 8'h80;

endpackage

// File: rtl/butterfly_sequencer_press_detect.sv
// rtl/butterfly_sequencer_press_detect.sv - rising-edge detector for the synchronised push-button
module press_detect (
  input  logic Clock,
  input  logic nReset,
  input  logic ReadyIn,
  output logic press
);

  logic ready_d, ready_q;

  always_comb begin
    ready_d = ReadyIn;
  end

  // Resets high so a button already held through reset never reads as a press.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) ready_q <= 1'b1;
    else         ready_q <= ready_d;
  end

  assign press = ReadyIn & ~ready_q;

endmodule

// File: rtl/butterfly_sequencer.sv
// rtl/butterfly_sequencer.sv - loads four operands by button, fires the butterfly, steps through results
module butterfly_sequencer
  import butterfly_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              ReadyIn,
  input  logic signed [7:0] SwData,
  output logic signed [7:0] opAr,
  output logic signed [7:0] opAi,
  output logic signed [7:0] opBr,
  output logic signed [7:0] opBi,
  output logic              bfStart,
  input  logic              bfDone,
  input  logic signed [7:0] resAr,
  input  logic signed [7:0] resAi,
  input  logic signed [7:0] resBr,
  input  logic signed [7:0] resBi,
  output logic signed [7:0] dataOut,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state_d, state_q;
  logic [1:0]            ld_idx_d, ld_idx_q;
  logic [1:0]            rd_idx_d, rd_idx_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  data_t [NUM_OPS-1:0]   opnd_d, opnd_q;
  data_t [NUM_OPS-1:0]   res_d, res_q;
  data_t                 data_out_d, data_out_q;
  logic                  press;

  press_detect u_press_detect (
    .Clock   (Clock),
    .nReset  (nReset),
    .ReadyIn (ReadyIn),
    .press   (press)
  );

  always_comb begin
    state_d    = state_q;
    ld_idx_d   = ld_idx_q;
    rd_idx_d   = rd_idx_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    res_d      = res_q;
    data_out_d = data_out_q;
    case (state_q)
      ST_LOAD: begin
        if (press) begin
          opnd_d[ld_idx_q] = SwData;
          data_out_d       = SwData;
          if (ld_idx_q == IDX_LAST) begin
            ld_idx_d = 2'd0;
            state_d  = ST_FIRE;
          end else begin
            ld_idx_d = ld_idx_q + 2'd1;
          end
        end
      end
      ST_FIRE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the last allowed cycle still beats the timeout.
        if (bfDone) begin
          res_d      = {resBi, resBr, resAi, resAr};
          rd_idx_d   = 2'd0;
          data_out_d = resAr;
          state_d    = ST_SHOW;
        end else if (cnt_q == CNT_LAST) begin
          data_out_d = ERR_CODE;
          state_d    = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHOW: begin
        if (press) begin
          if (rd_idx_q == IDX_LAST) begin
            ld_idx_d = 2'd0;
            state_d  = ST_LOAD;
          end else begin
            rd_idx_d   = rd_idx_q + 2'd1;
            data_out_d = res_q[rd_idx_d];
          end
        end
      end
      ST_ERR: begin
        data_out_d = ERR_CODE;
        if (press) begin
          ld_idx_d = 2'd0;
          state_d  = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= ST_LOAD;
      ld_idx_q   <= 2'd0;
      rd_idx_q   <= 2'd0;
      cnt_q      <= '0;
      opnd_q     <= '0;
      res_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_idx_q   <= ld_idx_d;
      rd_idx_q   <= rd_idx_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      res_q      <= res_d;
      data_out_q <= data_out_d;
    end
  end

  assign opAr    = opnd_q[0];
  assign opAi    = opnd_q[1];
  assign opBr    = opnd_q[2];
  assign opBi    = opnd_q[3];
  assign dataOut = data_out_q;
  assign bfStart = (state_q == ST_FIRE);
  assign busy    = (state_q == ST_FIRE) || (state_q == ST_WAIT);
  assign done    = (state_q == ST_SHOW);
  assign err     = (state_q == ST_ERR);

endmodule

// File: doc/butterfly_sequencer.md
BUTTERFLY_SEQUENCER -- requirements
Module: butterfly_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, maximum cycles spent in WAIT for bfDone before ERR.
REQ-002 Port: Clock  in  1  sole clock, all state updates on rising edge.
REQ-003 Port: nReset  in  1  asynchronous, active-low reset.
REQ-004 Port: ReadyIn  in  1  push-button level, already synchronised; each 0->1 transition is one press.
REQ-005 Port: SwData  in  8  signed switch operand.
REQ-006 Port: opAr, opAi, opBr, opBi  out  8 each  signed operands to butterfly datapath.
REQ-007 Port: bfStart  out  1  one-cycle start pulse to datapath.
REQ-008 Port: bfDone  in  1  datapath result-valid strobe.
REQ-009 Port: resAr, resAi, resBr, resBi  in  8 each  signed datapath results, valid while bfDone=1.
REQ-010 Port: dataOut  out  8  signed registered display value.
REQ-011 Port: busy  out  1  high in FIRE and WAIT.
REQ-012 Port: done  out  1  high in SHOW.
REQ-013 Port: err  out  1  high in ERR.

Function
REQ-014 FSM SHALL have states LOAD, FIRE, WAIT, SHOW, ERR; busy/done/err/bfStart SHALL be Moore decodes of state.
REQ-015 Press SHALL be ReadyIn=1 with registered ReadyIn_q=0; ReadyIn_q SHALL reset to 1, so a button held through reset is not a press.
REQ-016 LOAD: each press SHALL capture SwData into operand[ldIdx] (order Ar, Ai, Br, Bi), set dataOut to SwData, increment ldIdx.
REQ-017 Press with ldIdx=3 SHALL enter FIRE at that edge; bfStart SHALL be high for exactly the following cycle.
REQ-018 FIRE SHALL always advance to WAIT after one cycle and clear the timeout counter.
REQ-019 op* outputs SHALL be driven from operand registers and SHALL not change outside LOAD.
REQ-020 WAIT: bfDone=1 SHALL capture res* into result registers, set rdIdx=0, enter SHOW; dataOut SHALL equal resAr on the next cycle.
REQ-021 WAIT: counter increments each cycle; reaching TIMEOUT_CYCLES-1 without bfDone SHALL enter ERR.
REQ-022 bfDone and timeout in the same cycle: bfDone SHALL win (go to SHOW).
REQ-023 bfDone outside WAIT SHALL be ignored; presses in FIRE/WAIT SHALL be ignored.
REQ-024 SHOW: dataOut SHALL equal result[rdIdx]; each press increments rdIdx; press at rdIdx=3 SHALL enter LOAD with ldIdx=0, dataOut unchanged.
REQ-025 ERR: dataOut SHALL be -128 (0x80); a press SHALL enter LOAD with ldIdx=0; operand registers retained until overwritten.
REQ-026 Indices SHALL be 2 bits, wrap handled by state transition only; no arithmetic on data (pass-through, 8-bit signed).

Reset
REQ-027 nReset low SHALL immediately force state LOAD, ldIdx=0, rdIdx=0, counter=0, operands=0, results=0, dataOut=0, ReadyIn_q=1.
REQ-028 Reset outputs: bfStart=0, busy=0, done=0, err=0, op*=0.
REQ-029 Reset asserted mid-operation (any state) SHALL abandon the transaction; no bfStart after release until four new presses.

Structure
REQ-030 Shared package butterfly_pkg SHALL hold state_t enum, NUM_OPS=4, ERR_CODE=-128.
REQ-031 Press detection SHALL be a sub-module press_detect (Clock, nReset, ReadyIn -> press).

Verification
REQ-032 Four presses with SwData 5, -3, 7, 2 -> op*=(5,-3,7,2), single-cycle bfStart on cycle after 4th press, busy=1.
REQ-033 bfDone 3 cycles after bfStart with res*=(12,-1,-2,-5) -> done=1, dataOut 12; three presses -> -1, -2, -5; 4th press -> LOAD, done=0.
REQ-034 No bfDone, TIMEOUT_CYCLES=16 -> err=1 and dataOut=-128 after 16 WAIT cycles; one press -> LOAD, err=0.
REQ-035 bfDone coincident with final timeout cycle -> SHOW, err stays 0.
REQ-036 ReadyIn held 1 across reset release -> no capture; nReset pulsed during WAIT -> all outputs 0, next bfStart only after four presses.
REQ-037 Presses and bfDone pulses during FIRE/WAIT/LOAD respectively -> no state or operand change.
